peripheral_uart_tx_gen: RTL and testbench
=========================================

# peripheral_uart_tx_gen

Parametrised UART transmitter: next generation of the peripheral UART TX path. Adds a configurable data width up to `DATA_MAX` bits, an internal transmit FIFO, odd/even parity selection, per-frame latched configuration and a frame-done strobe. It sits between the bus-interface register block (AHB3/APB wrappers) and the `tx` pad. It shares the baud-divisor convention with the rest of the UART peripheral.

## Interface
- `DATA_MAX`, 9: maximum data bits per frame (5..9).
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `DIV_W`, 16: baud divisor width.
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset; one clock, synchronous, active-low.
- `cfg_en_i`  in  1  transmitter enable.
- `cfg_div_i`  in  DIV_W  bit period minus one, in clk cycles.
- `cfg_bits_i`  in  4  data bits per frame.
- `cfg_parity_en_i`  in  1  parity bit enable.
- `cfg_parity_odd_i`  in  1  1 = odd parity, 0 = even parity.
- `cfg_stop_bits_i`  in  1  0 = one stop bit, 1 = two stop bits.
- `tx_data_i`  in  DATA_MAX  write data, LSB first on line.
- `tx_valid_i`  in  1  write request.
- `tx_ready_o`  out  1  FIFO can accept.
- `fifo_level_o`  out  $clog2(FIFO_DEPTH)+1  entries held.
- `busy_o`  out  1  frame in progress.
- `tx_done_o`  out  1  one-cycle pulse at end of frame.
- `tx_o`  out  1  serial line, idle high, registered.
- `break_i`  in  1  line break request (only with the macro, see Configuration).

## Operation
- Push: `tx_valid_i && tx_ready_o` at a rising edge. `tx_ready_o = cfg_en_i && (fifo_level_o != FIFO_DEPTH)`.
- A push and a pop on the same edge leave the level unchanged. The FIFO never bypasses to the line.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, plus BREAK when the macro is defined.
- IDLE: if `cfg_en_i` and the FIFO is non-empty, pop the head into the shift register and go to START.
  - At the pop, latch `cfg_div_i`, effective bits, parity enable/odd and stop bits. Mid-frame config changes affect only the next frame.
- Effective bits: `cfg_bits_i` < 5 is treated as 5; `cfg_bits_i` > DATA_MAX is treated as DATA_MAX. Data bits at or above the effective count are ignored.
- START: line 0. DATA: line = shift[0]; shift right each bit.
- After the last data bit: go to PARITY if parity is enabled, else STOP1.
- Parity value:
  - Even: XOR of the transmitted data bits.
  - Odd: the inverse of that XOR.
- STOP1: line 1. At end of bit: go to STOP2 if two stop bits, else IDLE.
- STOP2: line 1, then IDLE.
- `tx_done_o` pulses for the single cycle in which the final stop bit's period ends.
- Bit timer: counter reloads to 0 on entry to each bit and increments every cycle. The bit ends on the cycle the counter equals the latched divisor. Each bit lasts exactly divisor+1 cycles.
- `busy_o = (state != IDLE)`.
- `cfg_en_i` low at any time:
  - Next edge: state IDLE, FIFO flushed (level 0), `tx_o` 1.
  - No `tx_done_o` for the aborted frame.
- Reset values: `tx_o`=1, `busy_o`=0, `tx_ready_o`=0, `fifo_level_o`=0, `tx_done_o`=0. Shift register and counters are 0.

## Timing
- Word pushed into an empty FIFO at edge N, with the FSM in IDLE:
  - pop at edge N+1;
  - `tx_o` falls after edge N+2.
- Frame length in cycles = (divisor+1) × (1 + bits + parity + stops).
- Back-to-back frames: with the FIFO non-empty, the pop occurs on the cycle after STOP→IDLE. Exactly one idle-high cycle separates frames.
- `fifo_level_o` updates on the edge after the push/pop.

## Configuration
- Macro `PERIPHERAL_UART_TX_BREAK_EN`.
- Defined:
  - `break_i` port exists.
  - In IDLE, `break_i`=1 takes priority over a pop and enters BREAK, with `tx_o`=0 while `break_i` is held. `busy_o`=1 in BREAK.
  - On release: one STOP1 period of mark, then IDLE, no `tx_done_o`.
  - `break_i` during a frame is ignored until IDLE.
- Undefined: no `break_i` port, no BREAK state; the line is only driven by frames.

## Structure
- Package `peripheral_uart_pkg`: FSM state enum and the minimum bit-count constant 5.
- Sub-module `peripheral_uart_tx_fifo`: synchronous FIFO with parametrised depth/width, push/pop/flush, and level output. The FSM, bit timer and parity live in the top.

## Test plan
- div=3, bits=8, no parity, 1 stop, push 0xA5:
  - `tx_o` = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, starting 2 edges after the push;
  - `tx_done_o` pulses once, 40 cycles after the start.
- bits=9, odd parity, 2 stops, data 0x1FF: nine 1s, parity 0, two stop bits; frame is 13 bits.
- Push FIFO_DEPTH+1 words with the line busy: `tx_ready_o` drops at level 8, the extra word is not accepted, all 8 words transmit in order with a single idle cycle between them.
- Change `cfg_div_i` from 3 to 7 mid-frame: the current frame keeps 4-cycle bits, the next frame uses 8-cycle bits.
- Drop `cfg_en_i` mid-DATA with 3 words queued:
  - next edge `tx_o`=1, `busy_o`=0, `fifo_level_o`=0;
  - no `tx_done_o`.
- With the macro defined, hold `break_i` 20 cycles in IDLE with the FIFO non-empty: `tx_o` low for 20 cycles, then one mark bit, then the queued frame.

Source files
------------

// File: rtl/peripheral_uart_pkg.sv
// Shared types and constants for the peripheral UART transmit path.
// ST_BREAK exists only when PERIPHERAL_UART_TX_BREAK_EN is defined.
package peripheral_uart_pkg;

  localparam int unsigned MIN_BITS = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
`ifdef PERIPHERAL_UART_TX_BREAK_EN
    ,
    ST_BREAK  = 3'd6
`endif
  } tx_state_e;

endpackage

// File: rtl/peripheral_uart_tx_fifo.sv
// Synchronous FIFO for the UART transmitter: push/pop/flush and fill level.
// DEPTH must be a power of two so the pointers wrap naturally.
module peripheral_uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 9
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign data_o  = mem_q[rptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    mem_d   = mem_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wptr_q] = data_i;
        wptr_d        = wptr_q + AW'(1);
      end
      if (pop_ok) begin
        rptr_d = rptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/peripheral_uart_tx_gen.sv
// UART transmitter with TX FIFO, 5..DATA_MAX data bits, optional parity and 1/2 stop bits.
// Define PERIPHERAL_UART_TX_BREAK_EN to add the break_i port and the line-break state.
module peripheral_uart_tx_gen
  import peripheral_uart_pkg::*;
#(
  parameter int unsigned DATA_MAX   = 9,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          cfg_en_i,
  input  logic [DIV_W-1:0]              cfg_div_i,
  input  logic [3:0]                    cfg_bits_i,
  input  logic                          cfg_parity_en_i,
  input  logic                          cfg_parity_odd_i,
  input  logic                          cfg_stop_bits_i,
  input  logic [DATA_MAX-1:0]           tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          busy_o,
  output logic                          tx_done_o,
`ifdef PERIPHERAL_UART_TX_BREAK_EN
  input  logic                          break_i,
`endif
  output logic                          tx_o
);

  localparam logic [3:0] BITS_MIN = 4'(MIN_BITS);
  localparam logic [3:0] BITS_MAX = 4'(DATA_MAX);

  tx_state_e             state_q, state_d;
  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [DATA_MAX-1:0]   shift_q, shift_d;
  logic [3:0]            idx_q, idx_d;
  logic [3:0]            bits_q, bits_d;
  logic                  par_q, par_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic                  frame_q, frame_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  bit_end_c;
  logic [3:0]            bits_eff_c;
  logic                  fifo_push_c, fifo_pop_c, fifo_flush_c;
  logic                  fifo_empty, fifo_full;
  logic [DATA_MAX-1:0]   fifo_data;

  assign tx_ready_o  = cfg_en_i && !fifo_full;
  assign fifo_push_c = tx_valid_i && tx_ready_o;
  assign tx_o        = tx_q;
  assign busy_o      = busy_q;
  assign tx_done_o   = done_q;

  peripheral_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_MAX)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (fifo_push_c),
    .data_i  (tx_data_i),
    .pop_i   (fifo_pop_c),
    .flush_i (fifo_flush_c),
    .data_o  (fifo_data),
    .level_o (fifo_level_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Clamp the requested data width into [MIN_BITS, DATA_MAX].
  always_comb begin
    bits_eff_c = cfg_bits_i;
    if (cfg_bits_i < BITS_MIN) begin
      bits_eff_c = BITS_MIN;
    end else if (cfg_bits_i > BITS_MAX) begin
      bits_eff_c = BITS_MAX;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    bits_d       = bits_q;
    par_d        = par_q;
    par_en_d     = par_en_q;
    stop2_d      = stop2_q;
    frame_d      = frame_q;
    tx_d         = 1'b1;
    done_d       = 1'b0;
    fifo_pop_c   = 1'b0;
    fifo_flush_c = 1'b0;
    bit_end_c    = (cnt_q == div_q);

    if (state_q != ST_IDLE) begin
      cnt_d = bit_end_c ? '0 : cnt_q + DIV_W'(1);
    end

    // tx_d follows the current state, so the line trails the FSM by one cycle.
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
`ifdef PERIPHERAL_UART_TX_BREAK_EN
        if (cfg_en_i && break_i) begin
          state_d = ST_BREAK;
          div_d   = cfg_div_i;
          stop2_d = 1'b0;
          frame_d = 1'b0;
        end else
`endif
        if (cfg_en_i && !fifo_empty) begin
          fifo_pop_c = 1'b1;
          shift_d    = fifo_data;
          div_d      = cfg_div_i;
          bits_d     = bits_eff_c;
          par_en_d   = cfg_parity_en_i;
          par_d      = cfg_parity_odd_i;
          stop2_d    = cfg_stop_bits_i;
          frame_d    = 1'b1;
          idx_d      = '0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_end_c) state_d = ST_DATA;
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (bit_end_c) begin
          shift_d = shift_q >> 1;
          par_d   = par_q ^ shift_q[0];
          idx_d   = idx_q + 4'd1;
          if (idx_q == bits_q - 4'd1) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP1;
          end
        end
      end
      ST_PARITY: begin
        tx_d = par_q;
        if (bit_end_c) state_d = ST_STOP1;
      end
      ST_STOP1: begin
        if (bit_end_c) begin
          if (stop2_q) begin
            state_d = ST_STOP2;
          end else begin
            state_d = ST_IDLE;
            done_d  = frame_q;
          end
        end
      end
      ST_STOP2: begin
        if (bit_end_c) begin
          state_d = ST_IDLE;
          done_d  = frame_q;
        end
      end
`ifdef PERIPHERAL_UART_TX_BREAK_EN
      ST_BREAK: begin
        tx_d  = 1'b0;
        cnt_d = '0;
        if (!break_i) state_d = ST_STOP1;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Disable aborts everything: idle line, empty FIFO, no completion strobe.
    if (!cfg_en_i) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      tx_d         = 1'b1;
      done_d       = 1'b0;
      fifo_pop_c   = 1'b0;
      fifo_flush_c = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      bits_q   <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      frame_q  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      bits_q   <= bits_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
      frame_q  <= frame_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_peripheral_uart_tx_gen.sv
// Self-checking bench for peripheral_uart_tx_gen: randomized frames against a line-level model.
// Define PERIPHERAL_UART_TX_BREAK_EN to also exercise the break feature.
`timescale 1ns/1ps
module tb_peripheral_uart_tx_gen;

  localparam int unsigned DATA_MAX   = 9;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned DIV_W      = 16;
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic                clk_i = 1'b0;
  logic                rstn_i;
  logic                cfg_en_i;
  logic [DIV_W-1:0]    cfg_div_i;
  logic [3:0]          cfg_bits_i;
  logic                cfg_parity_en_i;
  logic                cfg_parity_odd_i;
  logic                cfg_stop_bits_i;
  logic [DATA_MAX-1:0] tx_data_i;
  logic                tx_valid_i;
  logic                tx_ready_o;
  logic [LVL_W-1:0]    fifo_level_o;
  logic                busy_o;
  logic                tx_done_o;
  logic                tx_o;
`ifdef PERIPHERAL_UART_TX_BREAK_EN
  logic                break_i;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [8:0] data;
    int         div;
    int         bits;
    bit         par_en;
    bit         odd;
    bit         stop2;
  } frame_t;

  typedef bit bitq_t[$];

  peripheral_uart_tx_gen #(
    .DATA_MAX   (DATA_MAX),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .cfg_en_i         (cfg_en_i),
    .cfg_div_i        (cfg_div_i),
    .cfg_bits_i       (cfg_bits_i),
    .cfg_parity_en_i  (cfg_parity_en_i),
    .cfg_parity_odd_i (cfg_parity_odd_i),
    .cfg_stop_bits_i  (cfg_stop_bits_i),
    .tx_data_i        (tx_data_i),
    .tx_valid_i       (tx_valid_i),
    .tx_ready_o       (tx_ready_o),
    .fifo_level_o     (fifo_level_o),
    .busy_o           (busy_o),
    .tx_done_o        (tx_done_o),
`ifdef PERIPHERAL_UART_TX_BREAK_EN
    .break_i          (break_i),
`endif
    .tx_o             (tx_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference line sequence: start, LSB-first data, optional parity, stop bit(s).
  function automatic bitq_t frame_bits(input frame_t f);
    bitq_t q;
    int    eff;
    int    ones;
    eff  = (f.bits < 5) ? 5 : ((f.bits > 9) ? 9 : f.bits);
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < eff; i++) begin
      q.push_back(f.data[i]);
      ones += int'(f.data[i]);
    end
    if (f.par_en) q.push_back(((ones % 2) == 1) ^ f.odd);
    q.push_back(1'b1);
    if (f.stop2) q.push_back(1'b1);
    return q;
  endfunction

  function automatic frame_t mk(input logic [8:0] d);
    frame_t f;
    f.data   = d;
    f.div    = int'(cfg_div_i);
    f.bits   = int'(cfg_bits_i);
    f.par_en = cfg_parity_en_i;
    f.odd    = cfg_parity_odd_i;
    f.stop2  = cfg_stop_bits_i;
    return f;
  endfunction

  task automatic push(input logic [8:0] d);
    @(negedge clk_i);
    tx_valid_i = 1'b1;
    tx_data_i  = d;
    @(posedge clk_i);
    #1 tx_valid_i = 1'b0;
  endtask

  task automatic rand_cfg();
    cfg_div_i        = DIV_W'($urandom_range(0, 4));
    cfg_bits_i       = 4'($urandom_range(0, 15));
    cfg_parity_en_i  = 1'($urandom_range(0, 1));
    cfg_parity_odd_i = 1'($urandom_range(0, 1));
    cfg_stop_bits_i  = 1'($urandom_range(0, 1));
  endtask

  // Waits for a start bit (exp_wait>0: exact number of negedges), then checks every cycle of the frame.
  task automatic expect_frame(input frame_t f, input int exp_wait);
    bitq_t q;
    int    waited;
    int    n;
    q      = frame_bits(f);
    n      = q.size();
    waited = 0;
    do begin
      @(negedge clk_i);
      waited++;
      check_eq("done_outside_frame", 32'(tx_done_o), 0);
    end while (tx_o !== 1'b0 && waited < 400);
    check_eq("start_seen", 32'(tx_o), 0);
    if (tx_o !== 1'b0) return;
    if (exp_wait > 0) check_eq("start_latency", waited, exp_wait);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c <= f.div; c++) begin
        if (i != 0 || c != 0) @(negedge clk_i);
        check_eq("line", 32'(tx_o), 32'(q[i]));
        check_eq("done", 32'(tx_done_o), 32'(i == n - 1 && c == f.div));
        check_eq("busy", 32'(busy_o), 32'(!(i == n - 1 && c == f.div)));
      end
    end
  endtask

  initial begin
    logic [8:0] w [10];
    frame_t     fr [10];
    frame_t     fa, fb;
    int         bad;
    int         nw;

    rstn_i = 1'b0; cfg_en_i = 1'b0; cfg_div_i = DIV_W'(3); cfg_bits_i = 4'd8;
    cfg_parity_en_i = 1'b0; cfg_parity_odd_i = 1'b0; cfg_stop_bits_i = 1'b0;
    tx_data_i = '0; tx_valid_i = 1'b0;
`ifdef PERIPHERAL_UART_TX_BREAK_EN
    break_i = 1'b0;
`endif
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_tx", 32'(tx_o), 1);
    check_eq("rst_busy", 32'(busy_o), 0);
    check_eq("rst_ready", 32'(tx_ready_o), 0);
    check_eq("rst_level", 32'(fifo_level_o), 0);
    check_eq("rst_done", 32'(tx_done_o), 0);
    rstn_i = 1'b1;
    cfg_en_i = 1'b1;
    @(negedge clk_i);
    check_eq("en_ready", 32'(tx_ready_o), 1);
    check_eq("en_tx", 32'(tx_o), 1);

    // 0xA5, 8N1, 4-cycle bits: exact push-to-start latency.
    push(9'h0A5);
    @(negedge clk_i);
    check_eq("a5_level_after_push", 32'(fifo_level_o), 1);
    check_eq("a5_busy_before_pop", 32'(busy_o), 0);
    @(negedge clk_i);
    check_eq("a5_level_after_pop", 32'(fifo_level_o), 0);
    check_eq("a5_busy_after_pop", 32'(busy_o), 1);
    check_eq("a5_tx_before_start", 32'(tx_o), 1);
    expect_frame(mk(9'h0A5), 1);

    // 9 bits, odd parity, two stops.
    cfg_bits_i = 4'd9; cfg_parity_en_i = 1'b1; cfg_parity_odd_i = 1'b1; cfg_stop_bits_i = 1'b1;
    push(9'h1FF);
    expect_frame(mk(9'h1FF), 3);

    // Random single frames, including out-of-range bit counts.
    for (int k = 0; k < 8; k++) begin
      rand_cfg();
      w[0] = 9'($urandom);
      push(w[0]);
      expect_frame(mk(w[0]), 3);
    end

    // FIFO fill while the line is busy: ninth extra word must be dropped.
    cfg_div_i = DIV_W'(7); cfg_bits_i = 4'd8; cfg_parity_en_i = 1'b0; cfg_stop_bits_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      w[k]  = 9'($urandom);
      fr[k] = mk(w[k]);
    end
    fork
      begin
        push(w[0]);
        repeat (3) @(negedge clk_i);
        for (int j = 0; j < 9; j++) begin
          @(negedge clk_i);
          tx_valid_i = 1'b1;
          tx_data_i  = w[j + 1];
          check_eq("fill_level", 32'(fifo_level_o), j);
          check_eq("fill_ready", 32'(tx_ready_o), 32'(j < 8));
          @(posedge clk_i);
        end
        #1 tx_valid_i = 1'b0;
        @(negedge clk_i);
        check_eq("full_level", 32'(fifo_level_o), 8);
        check_eq("full_ready", 32'(tx_ready_o), 0);
      end
      begin
        expect_frame(fr[0], -1);
        for (int k = 1; k < 9; k++) expect_frame(fr[k], 2);
      end
    join
    bad = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1 || tx_done_o !== 1'b0) bad++;
    end
    check_eq("overflow_word_dropped", bad, 0);
    check_eq("drained_level", 32'(fifo_level_o), 0);

    // Divisor change mid-frame applies only to the next frame.
    cfg_div_i = DIV_W'(3);
    w[0] = 9'($urandom);
    w[1] = 9'($urandom);
    fa = mk(w[0]);
    fb = mk(w[1]);
    fb.div = 7;
    fork
      begin
        push(w[0]);
        repeat (3) @(negedge clk_i);
        cfg_div_i = DIV_W'(7);
        push(w[1]);
      end
      begin
        expect_frame(fa, -1);
        expect_frame(fb, 2);
      end
    join

    // Disable mid-DATA with three words queued.
    cfg_div_i = DIV_W'(3);
    for (int k = 0; k < 4; k++) push(9'($urandom));
    repeat (12) @(negedge clk_i);
    check_eq("abort_level_before", 32'(fifo_level_o), 3);
    check_eq("abort_busy_before", 32'(busy_o), 1);
    cfg_en_i = 1'b0;
    @(negedge clk_i);
    check_eq("abort_tx", 32'(tx_o), 1);
    check_eq("abort_busy", 32'(busy_o), 0);
    check_eq("abort_level", 32'(fifo_level_o), 0);
    check_eq("abort_ready", 32'(tx_ready_o), 0);
    bad = 0;
    for (int k = 0; k < 70; k++) begin
      if (k == 50) cfg_en_i = 1'b1;
      @(negedge clk_i);
      if (tx_o !== 1'b1 || tx_done_o !== 1'b0 || busy_o !== 1'b0) bad++;
    end
    check_eq("abort_quiet", bad, 0);
    check_eq("abort_flushed", 32'(fifo_level_o), 0);

    // Random back-to-back bursts.
    for (int k = 0; k < 5; k++) begin
      rand_cfg();
      nw = $urandom_range(2, 3);
      for (int j = 0; j < nw; j++) begin
        w[j]  = 9'($urandom);
        fr[j] = mk(w[j]);
      end
      fork
        begin
          for (int j = 0; j < nw; j++) push(w[j]);
        end
        begin
          expect_frame(fr[0], -1);
          for (int j = 1; j < nw; j++) expect_frame(fr[j], 2);
        end
      join
    end

`ifdef PERIPHERAL_UART_TX_BREAK_EN
    // Break held 20 cycles in idle with a word queued, then one mark bit, then the frame.
    cfg_div_i = DIV_W'(3); cfg_bits_i = 4'd8; cfg_parity_en_i = 1'b0; cfg_stop_bits_i = 1'b0;
    w[0] = 9'($urandom);
    @(negedge clk_i);
    break_i = 1'b1;
    tx_valid_i = 1'b1;
    tx_data_i = w[0];
    @(posedge clk_i);
    #1 tx_valid_i = 1'b0;
    for (int s = 0; s < 26; s++) begin
      @(negedge clk_i);
      check_eq("break_line", 32'(tx_o), 32'(s == 0 || s > 20));
      check_eq("break_done", 32'(tx_done_o), 0);
      if (s == 0) check_eq("break_busy", 32'(busy_o), 1);
      if (s == 19) break_i = 1'b0;
    end
    expect_frame(mk(w[0]), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
